// File: rtl/fetch_queue_if.sv
// Bundle of the fetch_queue handshake, cache-port and status signals.
// master = the fetch queue itself, slave = the pipeline/cache environment.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            deq;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_ins;
  logic            cmem_read;
  logic [XLEN-1:0] cmem_address;
  logic [3:0]      cmem_byte_enable;
  logic            cmem_resp;
  logic [XLEN-1:0] cmem_rdata;
  logic [31:0]     perf_stall;
  logic [31:0]     perf_redirects;

  modport master (
    input  redirect, redirect_pc, deq, cmem_resp, cmem_rdata,
    output out_valid, out_pc, out_ins, cmem_read, cmem_address,
           cmem_byte_enable, perf_stall, perf_redirects
  );

  modport slave (
    output redirect, redirect_pc, deq, cmem_resp, cmem_rdata,
    input  out_valid, out_pc, out_ins, cmem_read, cmem_address,
           cmem_byte_enable, perf_stall, perf_redirects
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: single-outstanding I-cache reader feeding a DEPTH-entry FIFO.
// Optional stall/redirect counters are built when FETCH_PERF_EN is defined.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'('h60)
) (
  input logic           clk,
  input logic           rst_n,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
  } entry_t;

  state_t          state_q, state_d;
  logic            read_q, read_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  ptr_t            rd_ptr_q, wr_ptr_q;
  cnt_t            count_q, count_after;
  entry_t          mem [DEPTH];
  logic            push, pop;

  // Redirect outranks both FIFO operations; a response collected while
  // redirecting belongs to the abandoned path.
  assign push        = (state_q == S_WAIT) && bus.cmem_resp && !bus.redirect;
  assign pop         = bus.deq && (count_q != '0) && !bus.redirect;
  assign count_after = count_q + cnt_t'(push) - cnt_t'(pop);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    req_addr_d = req_addr_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.redirect && count_q < cnt_t'(DEPTH)) begin
          state_d    = S_WAIT;
          read_d     = 1'b1;
          req_addr_d = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (bus.redirect) begin
          if (bus.cmem_resp) begin
            state_d = S_IDLE;
            read_d  = 1'b0;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (bus.cmem_resp) begin
          fetch_pc_d = fetch_pc_q + XLEN'(4);
          if (count_after < cnt_t'(DEPTH)) begin
            req_addr_d = fetch_pc_q + XLEN'(4);
          end else begin
            state_d = S_IDLE;
            read_d  = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (bus.cmem_resp) begin
          state_d = S_IDLE;
          read_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        read_d  = 1'b0;
      end
    endcase
    if (bus.redirect) fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      read_q     <= 1'b0;
      req_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      req_addr_q <= req_addr_d;
      fetch_pc_q <= fetch_pc_d;
      if (bus.redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
        count_q <= count_after;
      end
    end
  end

  // NOTE: the storage array is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{pc: req_addr_q, ins: bus.cmem_rdata};
  end

  assign bus.out_valid        = (count_q != '0);
  assign bus.out_pc           = mem[rd_ptr_q].pc;
  assign bus.out_ins          = mem[rd_ptr_q].ins;
  assign bus.cmem_read        = read_q;
  assign bus.cmem_address     = req_addr_q;
  assign bus.cmem_byte_enable = 4'hF;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, redir_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (!bus.out_valid && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bus.redirect   && redir_cnt_q != '1) redir_cnt_q <= redir_cnt_q + 32'd1;
    end
  end

  assign bus.perf_stall     = stall_cnt_q;
  assign bus.perf_redirects = redir_cnt_q;
`else
  assign bus.perf_stall     = 32'd0;
  assign bus.perf_redirects = 32'd0;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table plus hand-written redirect/drain sequences.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(32)) bus ();

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h60)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Cache model: auto mode answers lat cycles after the request is seen, manual mode is driven directly.
  logic        auto_mode = 1'b0;
  int          lat = 0;
  int          lat_cnt = 0;
  logic        man_resp = 1'b0;
  logic [31:0] man_rdata = 32'h0;

  always @(posedge clk) begin
    if (!bus.cmem_read || bus.cmem_resp) lat_cnt <= 0;
    else                                 lat_cnt <= lat_cnt + 1;
  end

  assign bus.cmem_resp  = auto_mode ? (bus.cmem_read && lat_cnt == lat) : man_resp;
  assign bus.cmem_rdata = auto_mode ? ins_of(bus.cmem_address) : man_rdata;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic am, input int l);
    auto_mode       = am;
    lat             = l;
    man_resp        = 1'b0;
    man_rdata       = 32'h0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.deq         = 1'b0;
    rst_n           = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        deq;
    logic        redirect;
    logic [31:0] rpc;
    logic        exp_read;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] exp_pc;
    logic        primed;

    // deq on an empty queue, fill to DEPTH, push+pop, flush on redirect, restart latency.
    vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h060, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h064, 1'b1, 32'h060};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h068, 1'b1, 32'h060};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h06C, 1'b1, 32'h060};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h060};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h060};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h064};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h070, 1'b1, 32'h064};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h064};
    vecs[9]  = '{1'b1, 1'b1, 32'h203, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200};
    vecs[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h204};

    // Reset values, sampled while reset is still asserted.
    auto_mode = 1'b1; lat = 0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.deq = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_bit("reset_out_valid", bus.out_valid, 1'b0);
    check_bit("reset_cmem_read", bus.cmem_read, 1'b0);
    check("reset_byte_enable", {28'b0, bus.cmem_byte_enable}, 32'hF);
    check("reset_perf_stall", bus.perf_stall, 32'h0);
    check("reset_perf_redirects", bus.perf_redirects, 32'h0);

    // Table: zero-wait cache.
    do_reset(1'b1, 0);
    for (int i = 0; i < 13; i++) begin
      bus.deq         = vecs[i].deq;
      bus.redirect    = vecs[i].redirect;
      bus.redirect_pc = vecs[i].rpc;
      step();
      check_bit($sformatf("vec%0d_cmem_read", i), bus.cmem_read, vecs[i].exp_read);
      if (vecs[i].exp_read) check($sformatf("vec%0d_cmem_address", i), bus.cmem_address, vecs[i].exp_addr);
      check_bit($sformatf("vec%0d_out_valid", i), bus.out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_out_pc", i), bus.out_pc, vecs[i].exp_pc);
        check($sformatf("vec%0d_out_ins", i), bus.out_ins, ins_of(vecs[i].exp_pc));
      end
    end
    bus.deq = 1'b0; bus.redirect = 1'b0;

    // Streaming with deq every cycle, zero-wait: no gaps once primed.
    do_reset(1'b1, 0);
    bus.deq = 1'b1;
    exp_pc = 32'h60;
    primed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.out_valid || primed) begin
        primed = 1'b1;
        check_bit("stream0_valid", bus.out_valid, 1'b1);
        check("stream0_pc", bus.out_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
    end
    check_bit("stream0_primed", primed, 1'b1);

    // Streaming with one cycle of cache latency: PCs stay strictly sequential.
    do_reset(1'b1, 1);
    bus.deq = 1'b1;
    exp_pc = 32'h60;
    for (int i = 0; i < 24; i++) begin
      step();
      if (bus.out_valid) begin
        check("stream1_pc", bus.out_pc, exp_pc);
        check("stream1_ins", bus.out_ins, ins_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
    end
    check("stream1_count", exp_pc, 32'h60 + 32'd4 * 32'd11);
    bus.deq = 1'b0;

    // Redirect while the 0x70 read is pending; resp arrives three cycles later.
    do_reset(1'b1, 0);
    for (int i = 0; i < 6; i++) step();
    auto_mode = 1'b0;
    bus.deq = 1'b1;
    step();
    bus.deq = 1'b0;
    step();
    check_bit("drain_pending_read", bus.cmem_read, 1'b1);
    check("drain_pending_addr", bus.cmem_address, 32'h70);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
    step();
    bus.redirect = 1'b0;
    check_bit("drain_valid_flushed", bus.out_valid, 1'b0);
    check_bit("drain_read_held", bus.cmem_read, 1'b1);
    check("drain_addr_held", bus.cmem_address, 32'h70);
    step();
    step();
    check("drain_addr_still_held", bus.cmem_address, 32'h70);
    man_resp = 1'b1; man_rdata = 32'hBAD0_BAD0;
    step();
    man_resp = 1'b0;
    check_bit("drain_done_read", bus.cmem_read, 1'b0);
    check_bit("drain_done_valid", bus.out_valid, 1'b0);
    step();
    check_bit("drain_restart_read", bus.cmem_read, 1'b1);
    check("drain_restart_addr", bus.cmem_address, 32'h200);
    auto_mode = 1'b1;
    step();
    check_bit("drain_first_valid", bus.out_valid, 1'b1);
    check("drain_first_pc", bus.out_pc, 32'h200);
    check("drain_first_ins", bus.out_ins, ins_of(32'h200));

    // Redirect coincident with resp: data dropped, no drain, unaligned target rounded down.
    do_reset(1'b0, 0);
    step();
    check("coinc_first_addr", bus.cmem_address, 32'h60);
    man_resp = 1'b1; man_rdata = 32'hBAD0_BAD0;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h152;
    step();
    man_resp = 1'b0; bus.redirect = 1'b0;
    check_bit("coinc_valid", bus.out_valid, 1'b0);
    check_bit("coinc_read_idle", bus.cmem_read, 1'b0);
    step();
    check_bit("coinc_restart_read", bus.cmem_read, 1'b1);
    check("coinc_restart_addr", bus.cmem_address, 32'h150);
    man_resp = 1'b1; man_rdata = ins_of(32'h150);
    step();
    man_resp = 1'b0;
    check_bit("coinc_new_valid", bus.out_valid, 1'b1);
    check("coinc_new_pc", bus.out_pc, 32'h150);

    // Two redirects during DRAIN: last one wins.
    do_reset(1'b0, 0);
    step();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h300;
    step();
    check("twice_drain_addr", bus.cmem_address, 32'h60);
    bus.redirect_pc = 32'h400;
    step();
    bus.redirect = 1'b0;
    check_bit("twice_drain_read", bus.cmem_read, 1'b1);
    man_resp = 1'b1;
    step();
    man_resp = 1'b0;
    check_bit("twice_idle_read", bus.cmem_read, 1'b0);
    step();
    check("twice_restart_addr", bus.cmem_address, 32'h400);
    auto_mode = 1'b1;
    step();
    check("twice_first_pc", bus.out_pc, 32'h400);

    // Asynchronous reset drops an outstanding request immediately.
    do_reset(1'b0, 0);
    step();
    check_bit("async_pre_read", bus.cmem_read, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_bit("async_read_dropped", bus.cmem_read, 1'b0);
    rst_n = 1'b1;

`ifdef FETCH_PERF_EN
    // 10 empty cycles, 3 of them with redirect.
    do_reset(1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      bus.redirect    = (i == 2 || i == 5 || i == 7);
      bus.redirect_pc = 32'h500;
      step();
    end
    bus.redirect = 1'b0;
    check("perf_redirects", bus.perf_redirects, 32'd3);
    check("perf_stall", bus.perf_stall, 32'd10);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    release dut.stall_cnt_q;
    step();
    check("perf_stall_top", bus.perf_stall, 32'hFFFF_FFFF);
    step();
    check("perf_stall_saturate", bus.perf_stall, 32'hFFFF_FFFF);
`else
    do_reset(1'b0, 0);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h500;
    step();
    bus.redirect = 1'b0;
    step();
    check("perf_stall_off", bus.perf_stall, 32'h0);
    check("perf_redirects_off", bus.perf_redirects, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
